// File: rtl/soc_sysid_pkg.sv
// soc_sysid_pkg: shared types and constants for the system-ID checker.
// Default expected words are also consumed by firmware header generation.
package soc_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ID   = 3'd1,
        WAIT_ID = 3'd2,
        RD_TS   = 3'd3,
        WAIT_TS = 3'd4,
        CHECK   = 3'd5,
        FIN     = 3'd6
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEF_ID = 32'h0000_0000;
    localparam logic [31:0] SYSID_DEF_TS = 32'h6949_6A68;
    localparam int unsigned SYSID_DEF_TIMEOUT = 255;

    // True while the ID word read is being issued or awaited.
    function automatic logic is_id_phase(state_t s);
        return (s == RD_ID) || (s == WAIT_ID);
    endfunction

    // True while the timestamp word read is being issued or awaited.
    function automatic logic is_ts_phase(state_t s);
        return (s == RD_TS) || (s == WAIT_TS);
    endfunction

endpackage

// File: rtl/soc_sysid_checker_if.sv
// soc_sysid_checker_if: Avalon-MM read-only bus between the checker
// (master) and the system-ID slave.
interface soc_sysid_checker_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );

endinterface

// File: rtl/soc_sysid_rd_xact.sv
// soc_sysid_rd_xact: one Avalon read at a time -- strobe, data pickup and
// optional timeout (enabled by SYSID_CHECK_TIMEOUT_EN).
module soc_sysid_rd_xact
    import soc_sysid_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = SYSID_DEF_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        launch,
    input  logic        launch_addr,
    soc_sysid_checker_if.master avm,
    output logic        accept,
    output logic        data_hit,
    output logic [31:0] rdata,
    output logic        tmo
);

    logic read_q;
    logic wait_q;
    logic active;

    assign active   = read_q | wait_q;
    assign accept   = read_q & ~avm.avm_waitrequest;
    // Data counts in the accepting cycle or while awaiting the response.
    assign data_hit = (accept & avm.avm_readdatavalid)
                    | (wait_q & avm.avm_readdatavalid);
    assign rdata    = avm.avm_readdata;

    assign avm.avm_read = read_q;

`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt;

    // Count cycles spent in the current request/wait phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (launch || accept) begin
            cnt <= '0;
        end else if (active) begin
            cnt <= cnt + 16'd1;
        end
    end

    // A response arriving together with the limit takes priority.
    assign tmo = active & (cnt == LIMIT) & ~data_hit;
`else
    assign tmo = 1'b0;
`endif

    // Strobe/address holding and wait-for-response tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_q          <= 1'b0;
            wait_q          <= 1'b0;
            avm.avm_address <= 1'b0;
        end else if (launch) begin
            read_q          <= 1'b1;
            wait_q          <= 1'b0;
            avm.avm_address <= launch_addr;
        end else if (data_hit || tmo) begin
            read_q <= 1'b0;
            wait_q <= 1'b0;
        end else if (accept) begin
            read_q <= 1'b0;
            wait_q <= 1'b1;
        end
    end

endmodule

// File: rtl/soc_sysid_checker.sv
// soc_sysid_checker: reads system-ID word and timestamp, compares to
// build-time values. Optional timeout via SYSID_CHECK_TIMEOUT_EN.
module soc_sysid_checker
    import soc_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEF_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEF_TS,
    parameter int unsigned TIMEOUT_CYCLES = SYSID_DEF_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    soc_sysid_checker_if.master avm
);

    state_t state;
    state_t state_n;

    logic        launch;
    logic        launch_addr;
    logic        x_accept;
    logic        x_data;
    logic [31:0] x_rdata;
    logic        x_tmo;

    soc_sysid_rd_xact #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_xact (
        .clock       (clock),
        .reset       (reset),
        .launch      (launch),
        .launch_addr (launch_addr),
        .avm         (avm),
        .accept      (x_accept),
        .data_hit    (x_data),
        .rdata       (x_rdata),
        .tmo         (x_tmo)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and read launch requests.
    always_comb begin
        state_n     = state;
        launch      = 1'b0;
        launch_addr = SYSID_ADDR_ID;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = RD_ID;
                    launch  = 1'b1;
                end
            end
            RD_ID, WAIT_ID: begin
                if (x_data) begin
                    state_n     = RD_TS;
                    launch      = 1'b1;
                    launch_addr = SYSID_ADDR_TS;
                end else if (x_tmo) begin
                    state_n = FIN;
                end else if (state == RD_ID && x_accept) begin
                    state_n = WAIT_ID;
                end
            end
            RD_TS, WAIT_TS: begin
                if (x_data) begin
                    state_n = CHECK;
                end else if (x_tmo) begin
                    state_n = FIN;
                end else if (state == RD_TS && x_accept) begin
                    state_n = WAIT_TS;
                end
            end
            CHECK:   state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered status, captured words and the pass/fail verdict.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            busy <= (state_n != IDLE) && (state_n != FIN);
            done <= (state_n == FIN);
            if (state == IDLE && start) begin
                id_ok       <= 1'b0;
                timeout_err <= 1'b0;
                id_value    <= '0;
                ts_value    <= '0;
            end
            if (x_data && is_id_phase(state)) begin
                id_value <= x_rdata;
            end
            if (x_data && is_ts_phase(state)) begin
                ts_value <= x_rdata;
            end
            if (state == CHECK) begin
                id_ok <= (id_value == EXPECTED_ID)
                      && (ts_value == EXPECTED_TS);
            end
            if (x_tmo) begin
                timeout_err <= 1'b1;
                id_ok       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_soc_sysid_checker.sv
// tb_soc_sysid_checker: directed vectors against a behavioural
// system-ID slave with programmable stall and latency per address.
module tb_soc_sysid_checker;
    import soc_sysid_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        timeout_err;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    soc_sysid_checker_if avm();

    soc_sysid_checker #(
        .EXPECTED_ID    (32'h0000_0000),
        .EXPECTED_TS    (32'h6949_6A68),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .id_ok       (id_ok),
        .timeout_err (timeout_err),
        .id_value    (id_value),
        .ts_value    (ts_value),
        .avm         (avm)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural slave state.
    logic [31:0] mem0, mem1;
    int wait_id, lat_id, wait_ts, lat_ts;
    bit in_req, pend;
    int stall_left, lat_left, accepts, lat;
    logic [31:0] pdata;

    task automatic slave_cfg(input logic [31:0] m0, input logic [31:0] m1,
                             input int wi, input int li,
                             input int wt, input int lt);
        mem0 = m0; mem1 = m1;
        wait_id = wi; lat_id = li; wait_ts = wt; lat_ts = lt;
        in_req = 0; pend = 0; accepts = 0;
    endtask

    // Slave response for the cycle that just started.
    always begin
        @(posedge clock);
        #1;
        avm.avm_waitrequest   = 1'b0;
        avm.avm_readdatavalid = 1'b0;
        avm.avm_readdata      = '0;
        if (!avm.avm_read) in_req = 0;
        if (pend) begin
            lat_left--;
            if (lat_left == 0) begin
                avm.avm_readdatavalid = 1'b1;
                avm.avm_readdata      = pdata;
                pend = 0;
            end
        end else if (avm.avm_read) begin
            if (!in_req) begin
                in_req = 1;
                stall_left = avm.avm_address ? wait_ts : wait_id;
            end
            if (stall_left > 0) begin
                avm.avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                in_req = 0;
                accepts++;
                pdata = avm.avm_address ? mem1 : mem0;
                lat   = avm.avm_address ? lat_ts : lat_id;
                if (lat == 0) begin
                    avm.avm_readdatavalid = 1'b1;
                    avm.avm_readdata      = pdata;
                end else begin
                    pend = 1;
                    lat_left = lat;
                end
            end
        end
    end

    // Done-pulse counter and strobe stability during stalls.
    int   done_cnt = 0;
    bit   stall_chk_en = 0;
    logic prev_stall = 1'b0;
    logic prev_addr = 1'b0;
    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
        if (stall_chk_en && prev_stall)
            chk("stall_hold", {avm.avm_read, avm.avm_address},
                {1'b1, prev_addr});
        prev_stall = stall_chk_en && avm.avm_read && avm.avm_waitrequest;
        prev_addr  = avm.avm_address;
    end

    // Pulse start in cycle 0; cyc returns the cycle done is seen.
    task automatic run(input bit second_start, output int cyc);
        int n;
        n = 0;
        @(negedge clock);
        start = 1'b1;
        while (n < 200) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 1) start = 1'b0;
            if (second_start && n == 2) start = 1'b1;
            if (second_start && n == 3) start = 1'b0;
            if (done) break;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
        cyc = n;
    endtask

    typedef struct {
        logic [31:0] m0;
        logic [31:0] m1;
        int          wi, li, wt, lt;
        logic        exp_ok;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc;
        int n;
        reset = 1'b1;
        start = 1'b0;
        avm.avm_waitrequest   = 1'b0;
        avm.avm_readdatavalid = 1'b0;
        avm.avm_readdata      = '0;
        slave_cfg(32'h0, 32'h6949_6A68, 0, 0, 0, 0);

        vecs[0] = '{32'h0000_0000, 32'h6949_6A68, 0, 0, 0, 0, 1'b1, 4};
        vecs[1] = '{32'h0000_0001, 32'h6949_6A68, 0, 0, 0, 0, 1'b0, 4};
        vecs[2] = '{32'h0000_0000, 32'h6949_6A68, 3, 2, 0, 0, 1'b1, 9};
        vecs[3] = '{32'h0000_0000, 32'h6949_6A67, 0, 0, 0, 0, 1'b0, 4};
        vecs[4] = '{32'h0000_0000, 32'h6949_6A68, 0, 1, 0, 0, 1'b1, 5};
        vecs[5] = '{32'h0000_0000, 32'h6949_6A68, 2, 0, 0, 0, 1'b1, 6};
        vecs[6] = '{32'h0000_0000, 32'h6949_6A68, 0, 0, 1, 2, 1'b1, 7};

        repeat (3) @(posedge clock);
        #1;
        chk("reset_outs",
            {busy, done, id_ok, timeout_err, id_value, ts_value,
             avm.avm_read, avm.avm_address},
            70'd0);
        @(negedge clock);
        reset = 1'b0;
        stall_chk_en = 1;

        for (int i = 0; i < 7; i++) begin
            slave_cfg(vecs[i].m0, vecs[i].m1, vecs[i].wi, vecs[i].li,
                      vecs[i].wt, vecs[i].lt);
            run(1'b0, cyc);
            chk($sformatf("v%0d_cycle", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_id_ok", i), {63'd0, id_ok},
                {63'd0, vecs[i].exp_ok});
            chk($sformatf("v%0d_id_value", i), {32'd0, id_value},
                {32'd0, vecs[i].m0});
            chk($sformatf("v%0d_ts_value", i), {32'd0, ts_value},
                {32'd0, vecs[i].m1});
            chk($sformatf("v%0d_busy_tmo", i), {62'd0, busy, timeout_err},
                64'd0);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
            repeat (2) @(posedge clock);
        end

        // Start while busy is dropped.
        slave_cfg(32'h0, 32'h6949_6A68, 0, 0, 0, 0);
        done_cnt = 0;
        run(1'b1, cyc);
        repeat (10) @(posedge clock);
        #1;
        chk("busy_start_cycle", 64'(cyc), 64'd4);
        chk("busy_start_dones", 64'(done_cnt), 64'd1);
        chk("busy_start_reads", 64'(accepts), 64'd2);
        chk("busy_start_idle", {63'd0, busy}, 64'd0);

        // Reset during WAIT_TS followed by a late response.
        stall_chk_en = 0;
        slave_cfg(32'h0, 32'h6949_6A68, 0, 0, 0, 4);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(busy && avm.avm_address && !avm.avm_read) && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("reach_wait_ts", 64'(n < 50), 64'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_reset_outs",
            {busy, done, id_ok, timeout_err, id_value, ts_value,
             avm.avm_read, avm.avm_address},
            70'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        chk("late_rdv_outs",
            {busy, done, id_ok, timeout_err, id_value, ts_value,
             avm.avm_read, avm.avm_address},
            70'd0);
        slave_cfg(32'h0, 32'h6949_6A68, 0, 0, 0, 0);
        run(1'b0, cyc);
        chk("after_reset_cycle", 64'(cyc), 64'd4);
        chk("after_reset_ok", {63'd0, id_ok}, 64'd1);
        repeat (2) @(posedge clock);

`ifdef SYSID_CHECK_TIMEOUT_EN
        // Slave stalls forever on the ID read.
        slave_cfg(32'h0, 32'h6949_6A68, 1000, 0, 0, 0);
        run(1'b0, cyc);
        chk("tmo_cycle", 64'(cyc), 64'd9);
        chk("tmo_err", {63'd0, timeout_err}, 64'd1);
        chk("tmo_id_ok", {63'd0, id_ok}, 64'd0);
        chk("tmo_read_drop", {63'd0, avm.avm_read}, 64'd0);
        repeat (2) @(posedge clock);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/soc_sysid_checker.md
# soc_sysid_checker

Avalon-MM read initiator that interrogates the system-ID slave at boot or on demand. On a start pulse it reads the ID word (address 0), then the timestamp word (address 1), and compares both against build-time expected values. The block sits on the SoC interconnect as a master next to the CPU data master. Its pass/fail result drives a board LED and a status bit readable by firmware.

## Interface
Parameters:
- EXPECTED_ID, 32'h0000_0000, expected system-ID word at slave address 0
- EXPECTED_TS, 32'h6949_6A68 (1766419048), expected timestamp word at slave address 1
- TIMEOUT_CYCLES, 255, per-transaction wait limit in clocks, range 1..65535; only used with the timeout feature

Ports (one clock domain; reset is asynchronous and active-high):
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to run a check; ignored unless the block is IDLE
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the result outputs are valid
- id_ok  out  1  high when both words matched; held until the next accepted start
- timeout_err  out  1  high when a transaction timed out; held until the next accepted start
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word
- avm_address  out  1  word address to the slave
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier

## Operation
- FSM states: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK, FIN.
- IDLE + start → RD_ID. The block clears id_ok, timeout_err, id_value and ts_value, and sets busy.
- RD_ID: avm_read=1, avm_address=0. Both hold stable until a cycle with avm_waitrequest=0, then → WAIT_ID.
- If avm_readdatavalid is already high in the accepting cycle, the data is captured there and the FSM goes straight to RD_TS.
- WAIT_ID: avm_read=0. On avm_readdatavalid, id_value ← avm_readdata, then → RD_TS.
- RD_TS/WAIT_TS: same as the ID read, with address 1, capturing into ts_value, then → CHECK.
- CHECK: id_ok ← (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TS), then → FIN.
- FIN: done=1 for one cycle, busy=0 in the same cycle, then → IDLE.
- The block never issues a new read while one is outstanding; at most one read is in flight.
- A start while busy is dropped; it is neither queued nor allowed to restart the sequence.
- readdatavalid seen in any state other than RD_*/WAIT_* is ignored.
- Reset mid-sequence: the FSM returns to IDLE and all outputs go to reset values. Any read response that arrives afterwards is ignored.

## Timing
- Reset values: busy=0, done=0, id_ok=0, timeout_err=0, id_value=0, ts_value=0, avm_read=0, avm_address=0.
- All outputs are registered.
- Zero-wait, zero-latency slave (readdatavalid in the accepting cycle):
  - start in cycle 0.
  - avm_read high in cycles 1 (addr 0) and 2 (addr 1).
  - CHECK in cycle 3.
  - done and final id_ok/ts_value visible in cycle 4.
- Each waitrequest cycle and each cycle of read latency adds one cycle.

## Configuration
- Macro SYSID_CHECK_TIMEOUT_EN.
- When defined: a 16-bit counter runs in every RD_*/WAIT_* state and clears on each state entry.
  - When the counter reaches TIMEOUT_CYCLES: avm_read drops, timeout_err=1, id_ok=0, and the FSM goes → FIN (done still pulses).
  - If a valid response arrives in the same cycle as the timeout, the response wins.
- When undefined: no counter, and timeout_err is tied to 0. The FSM waits indefinitely.

## Structure
- Package soc_sysid_pkg holds:
  - the state enum;
  - SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1;
  - the default expected-value constants, shared with firmware header generation.
- Optional sub-module soc_sysid_rd_xact encapsulates one Avalon read: it holds the strobe, collects the data and runs the timeout. The top instantiates it once and sequences the two addresses through it.

## Test plan
- Zero-latency slave returning 0 at address 0 and 0x69496A68 at address 1; start → done in cycle 4, id_ok=1, ts_value=0x69496A68.
- Slave returning 0x00000001 at address 0 → done, id_ok=0, id_value=1.
- waitrequest held 3 cycles on the ID read, then readdatavalid 2 cycles after acceptance → avm_read/avm_address stable during the stall; done in cycle 9, id_ok=1.
- Second start pulse at cycle 2 of a run → ignored; exactly one done pulse and exactly two read strobes accepted.
- With SYSID_CHECK_TIMEOUT_EN defined and TIMEOUT_CYCLES=8: waitrequest stuck at 1 → avm_read drops after 8 cycles, timeout_err=1, id_ok=0, done pulses.
- Reset asserted while in WAIT_TS, then a late readdatavalid → all outputs read 0 and the FSM is IDLE; the next start completes normally.
